// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// State codes are listed in frame order: LEN_HI, LEN_LO, then DATA_HI/DATA_LO
// pairs, then the optional CSUM byte.
package rom_loader_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;
    localparam int BYTE_W     = 8;

    // Frame field order: length bytes first, then word bytes, high byte first
    localparam int FRAME_LEN_BYTES  = 2;
    localparam int FRAME_WORD_BYTES = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LEN_HI  = 3'd1;
    localparam state_t ST_LEN_LO  = 3'd2;
    localparam state_t ST_DATA_HI = 3'd3;
    localparam state_t ST_DATA_LO = 3'd4;
    localparam state_t ST_CSUM    = 3'd5;
    localparam state_t ST_DONE    = 3'd6;
    localparam state_t ST_ERROR   = 3'd7;

    // States in which the loader is waiting for a frame byte
    function automatic logic is_rx_state(input state_t st);
        logic r;
        case (st)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM: r = 1'b1;
            default:                                               r = 1'b0;
        endcase
        return r;
    endfunction

    // Running XOR checksum step over one frame byte
    function automatic logic [BYTE_W-1:0] csum_step(input logic [BYTE_W-1:0] acc,
                                                    input logic [BYTE_W-1:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/rom_loader_timeout.sv
// Idle watchdog for the loader: counts cycles while enabled, restarts on clear,
// and flags expiry so the loader leaves its busy states exactly LIMIT cycles
// after the last clear.
module rom_loader_timeout #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             expired_r;

    // Next count: restart on clear, saturate at the last value, idle at zero
    always_comb begin
        cnt_s = cnt_r;
        if (clear) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (enable) begin
            if (cnt_r == LAST) begin
                cnt_s = cnt_r;
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_s = {CNT_W{1'b0}};
        end
    end

    // Count register and registered expiry flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            expired_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            expired_r <= enable && !clear && (cnt_s == LAST);
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/rom_loader.sv
// Boot-time program loader: parses a LEN/DATA byte frame from a valid/ready
// stream, writes 16-bit words to instruction memory from address 0 and holds
// the CPU in reset until the image is in place.
// Optional trailing XOR checksum byte: define ROM_LOADER_CHECKSUM_EN.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int MEM_DEPTH      = 32768,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int WC_W = ADDR_W + 1;

    state_t              state_r,    state_s;
    logic [15:0]         len_r,      len_s;
    logic [BYTE_W-1:0]   hi_r,       hi_s;
    logic                mem_we_r,   mem_we_s;
    logic [ADDR_W-1:0]   addr_r,     addr_s;
    logic [DATA_W-1:0]   wdata_r,    wdata_s;
    logic [WC_W-1:0]     wc_r,       wc_s;
    logic                busy_r,     busy_s;
    logic                done_r,     done_s;
    logic                error_r,    error_s;
    logic                hold_r,     hold_s;
    logic                rx_ready_r, rx_ready_s;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum_r,     csum_s;
`endif

    logic        hs_s;
    logic        start_acc_s;
    logic        last_word_s;
    logic [15:0] len_full_s;
    logic        tmo_expired_s;

    rom_loader_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (hs_s || start_acc_s),
        .enable  (busy_r),
        .expired (tmo_expired_s)
    );

    // Frame FSM, byte assembly and write-port sequencing
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        hi_s        = hi_r;
        mem_we_s    = 1'b0;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        wc_s        = wc_r;
        busy_s      = busy_r;
        done_s      = done_r;
        error_s     = error_r;
        hold_s      = hold_r;
        rx_ready_s  = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
        csum_s      = csum_r;
`endif
        hs_s        = rx_valid && rx_ready_r;
        start_acc_s = 1'b0;
        len_full_s  = {len_r[15:8], rx_data};
        last_word_s = ((32'(wc_r) + 32'd1) == 32'(len_r));

        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    state_s     = ST_LEN_HI;
                    done_s      = 1'b0;
                    error_s     = 1'b0;
                    wc_s        = {WC_W{1'b0}};
                    addr_s      = {ADDR_W{1'b0}};
                    busy_s      = 1'b1;
                    hold_s      = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_s      = {BYTE_W{1'b0}};
`endif
                end else begin
                    state_s = state_r;
                end
            end
            ST_LEN_HI: begin
                if (hs_s) begin
                    len_s   = {rx_data, len_r[7:0]};
                    state_s = ST_LEN_LO;
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_s  = csum_step(csum_r, rx_data);
`endif
                end else begin
                    state_s = state_r;
                end
            end
            ST_LEN_LO: begin
                if (hs_s) begin
                    len_s = len_full_s;
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_s = csum_step(csum_r, rx_data);
`endif
                    // An empty image or one larger than the memory is rejected up front
                    if ((len_full_s == 16'd0) || (32'(len_full_s) > 32'(MEM_DEPTH))) begin
                        state_s = ST_ERROR;
                    end else begin
                        state_s = ST_DATA_HI;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_DATA_HI: begin
                if (hs_s) begin
                    hi_s    = rx_data;
                    state_s = ST_DATA_LO;
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_s  = csum_step(csum_r, rx_data);
`endif
                end else begin
                    state_s = state_r;
                end
            end
            ST_DATA_LO: begin
                if (mem_we_r) begin
                    // Write cycle ends: advance, but never step the address past the last word
                    wc_s = wc_r + WC_W'(1);
                    if (last_word_s) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        state_s = ST_CSUM;
`else
                        state_s = ST_DONE;
`endif
                    end else begin
                        addr_s  = addr_r + ADDR_W'(1);
                        state_s = ST_DATA_HI;
                    end
                end else if (hs_s) begin
                    wdata_s  = DATA_W'({hi_r, rx_data});
                    mem_we_s = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_s   = csum_step(csum_r, rx_data);
`endif
                end else begin
                    state_s = state_r;
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (hs_s) begin
                    if (rx_data == csum_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ERROR;
                    end
                end else begin
                    state_s = state_r;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Stalled stream: abandon the load; words already written stay in memory
        if (busy_r && tmo_expired_s) begin
            state_s  = ST_ERROR;
            mem_we_s = 1'b0;
        end else begin
            mem_we_s = mem_we_s;
        end

        case (state_s)
            ST_DONE: begin
                busy_s = 1'b0;
                done_s = 1'b1;
                hold_s = 1'b0;
            end
            ST_ERROR: begin
                busy_s  = 1'b0;
                error_s = 1'b1;
                hold_s  = 1'b1;
            end
            default: begin
                busy_s = busy_s;
            end
        endcase

        // No byte is taken while a word is being written
        rx_ready_s = is_rx_state(state_s) && !mem_we_s;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            len_r      <= 16'd0;
            hi_r       <= {BYTE_W{1'b0}};
            mem_we_r   <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            wc_r       <= {WC_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            hold_r     <= 1'b1;
            rx_ready_r <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_r     <= {BYTE_W{1'b0}};
`endif
        end else begin
            state_r    <= state_s;
            len_r      <= len_s;
            hi_r       <= hi_s;
            mem_we_r   <= mem_we_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            wc_r       <= wc_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            error_r    <= error_s;
            hold_r     <= hold_s;
            rx_ready_r <= rx_ready_s;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_r     <= csum_s;
`endif
        end
    end

    assign rx_ready   = rx_ready_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;
    assign cpu_hold   = hold_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign word_count = wc_r;

endmodule
